// File: rtl/piso_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module      : piso_bit_serializer
// Description : Parallel-in, serial-out bit feeder with a one-word holding
//               register so back-to-back words stream without idle gaps.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [0:0]       r_state,     nxt_state;
    logic [CW-1:0]    r_cnt,       nxt_cnt;
    logic [WIDTH-1:0] r_shreg,     nxt_shreg;
    logic             r_x,         nxt_x;
    logic [WIDTH-1:0] r_hold,      nxt_hold;
    logic             r_hold_full, nxt_hold_full;

    logic             w_xfer;
    logic             w_at_end;
    logic [WIDTH-1:0] w_load_word;
    logic             w_load_bit;
    logic [WIDTH-1:0] w_load_rest;
    logic             w_shift_bit;
    logic [WIDTH-1:0] w_shift_rest;

    assign w_xfer      = din_valid && din_ready;
    assign w_at_end    = (r_state == S_IDLE) || (r_cnt == c_last);
    assign w_load_word = r_hold_full ? r_hold : din;

    // The first bit of a word goes straight to x on the load edge; the
    // shift register keeps only the bits that are still to come.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_load_bit   = w_load_word[WIDTH-1];
            assign w_load_rest  = {w_load_word[WIDTH-2:0], 1'b0};
            assign w_shift_bit  = r_shreg[WIDTH-1];
            assign w_shift_rest = {r_shreg[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_load_bit   = w_load_word[0];
            assign w_load_rest  = {1'b0, w_load_word[WIDTH-1:1]};
            assign w_shift_bit  = r_shreg[0];
            assign w_shift_rest = {1'b0, r_shreg[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_shreg     <= '0;
            r_x         <= IDLE_BIT;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else begin
            r_state     <= nxt_state;
            r_cnt       <= nxt_cnt;
            r_shreg     <= nxt_shreg;
            r_x         <= nxt_x;
            r_hold      <= nxt_hold;
            r_hold_full <= nxt_hold_full;
        end
    end

    always_comb begin
        nxt_state     = r_state;
        nxt_cnt       = r_cnt;
        nxt_shreg     = r_shreg;
        nxt_x         = r_x;
        nxt_hold      = r_hold;
        nxt_hold_full = r_hold_full;
        if (w_at_end) begin
            // A full hold register has priority; din_ready is low then anyway.
            if (r_hold_full || w_xfer) begin
                nxt_state     = S_SHIFT;
                nxt_cnt       = '0;
                nxt_shreg     = w_load_rest;
                nxt_x         = w_load_bit;
                nxt_hold_full = 1'b0;
            end else begin
                nxt_state = S_IDLE;
                nxt_cnt   = '0;
                nxt_x     = IDLE_BIT;
            end
        end else begin
            nxt_cnt   = r_cnt + CW'(1);
            nxt_shreg = w_shift_rest;
            nxt_x     = w_shift_bit;
            if (w_xfer) begin
                nxt_hold      = din;
                nxt_hold_full = 1'b1;
            end
        end
    end

    always_comb begin
        din_ready = rst && !r_hold_full;
        x         = r_x;
        x_valid   = (r_state == S_SHIFT);
        last      = (r_state == S_SHIFT) && (r_cnt == c_last);
        busy      = (r_state == S_SHIFT) || r_hold_full;
    end

endmodule
`default_nettype wire

// File: tb/tb_piso_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_bit_serializer
// Description : Bench for piso_bit_serializer; MSB-first and LSB-first
//               instances share stimulus and are compared to a bit-queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_bit_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         din_valid = 1'b0;
    logic [W-1:0] din = '0;

    logic din_ready_m, x_m, x_valid_m, last_m, busy_m;
    logic din_ready_l, x_l, x_valid_l, last_l, busy_l;

    int ntests = 0;
    int nfail  = 0;

    // Model: queue of bits still to appear on x; element 0 is on x right now.
    int q_m[$];
    int q_l[$];

    logic [23:0] acc_m, acc_l;
    int          vcnt_m, run_m, maxrun_m;
    logic        xfer;

    piso_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(din_ready_m), .x(x_m), .x_valid(x_valid_m),
        .last(last_m), .busy(busy_m)
    );

    piso_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(din_ready_l), .x(x_l), .x_valid(x_valid_l),
        .last(last_l), .busy(busy_l)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_acc();
        acc_m    = '0;
        acc_l    = '0;
        vcnt_m   = 0;
        run_m    = 0;
        maxrun_m = 0;
    endtask

    task automatic step(input logic r, input logic v, input logic [W-1:0] d);
        logic exp_rdy;
        @(negedge clk);
        rst       = r;
        din_valid = v;
        din       = d;
        #1;
        // More than one word's worth of bits queued means the hold register is full.
        exp_rdy = r && (q_m.size() <= W);
        chk("din_ready_m", 32'(din_ready_m), 32'(exp_rdy));
        chk("din_ready_l", 32'(din_ready_l), 32'(exp_rdy));
        xfer = v && exp_rdy;
        @(posedge clk);
        if (!r) begin
            q_m.delete();
            q_l.delete();
        end else begin
            if (q_m.size() > 0) void'(q_m.pop_front());
            if (q_l.size() > 0) void'(q_l.pop_front());
            if (xfer) begin
                for (int k = 0; k < W; k++) begin
                    q_m.push_back(int'(d[W-1-k]));
                    q_l.push_back(int'(d[k]));
                end
            end
        end
        #1;
        chk("x_valid_m", 32'(x_valid_m), 32'(q_m.size() > 0));
        chk("x_m",       32'(x_m),       32'((q_m.size() > 0) ? q_m[0] : 0));
        chk("last_m",    32'(last_m),    32'((q_m.size() > 0) && ((q_m.size() - 1) % W == 0)));
        chk("busy_m",    32'(busy_m),    32'(q_m.size() > 0));
        chk("x_valid_l", 32'(x_valid_l), 32'(q_l.size() > 0));
        chk("x_l",       32'(x_l),       32'((q_l.size() > 0) ? q_l[0] : 0));
        chk("last_l",    32'(last_l),    32'((q_l.size() > 0) && ((q_l.size() - 1) % W == 0)));
        chk("busy_l",    32'(busy_l),    32'(q_l.size() > 0));
        if (x_valid_m) begin
            acc_m = {acc_m[22:0], x_m};
            vcnt_m++;
            run_m++;
            if (run_m > maxrun_m) maxrun_m = run_m;
        end else begin
            run_m = 0;
        end
        if (x_valid_l) acc_l = {acc_l[22:0], x_l};
    endtask

    initial begin
        logic [W-1:0] words [3];
        int           wi;
        int           stalls;
        logic         r, v, pend;
        logic [W-1:0] d;

        // Reset then idle
        clear_acc();
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        repeat (3) step(1'b1, 1'b0, '0);

        // Single word, MSB first
        clear_acc();
        step(1'b1, 1'b1, 8'hF9);
        repeat (9) step(1'b1, 1'b0, '0);
        chk("single_bits", 32'(acc_m[7:0]), 32'h0000_00F9);
        chk("single_vcnt", 32'(vcnt_m), 32'd8);

        // LSB order
        clear_acc();
        step(1'b1, 1'b1, 8'h9F);
        repeat (9) step(1'b1, 1'b0, '0);
        chk("lsb_bits", 32'(acc_l[7:0]), 32'h0000_00F9);
        chk("msb_of_9f", 32'(acc_m[7:0]), 32'h0000_009F);

        // Streaming with backpressure on the third word
        clear_acc();
        words[0] = 8'hF9;
        words[1] = 8'h79;
        words[2] = 8'hA5;
        wi       = 0;
        stalls   = 0;
        for (int c = 0; c < 40; c++) begin
            if (wi < 3) begin
                step(1'b1, 1'b1, words[wi]);
                if (xfer) wi++;
                else stalls++;
            end else begin
                step(1'b1, 1'b0, '0);
            end
        end
        chk("stream_words", 32'(wi), 32'd3);
        chk("stream_bits", 32'(acc_m), 32'h00F9_79A5);
        chk("stream_run", 32'(maxrun_m), 32'd24);
        chk("stream_stalls", 32'(stalls), 32'd7);

        // Reset mid-word with hold full
        clear_acc();
        step(1'b1, 1'b1, 8'hF9);
        step(1'b1, 1'b1, 8'h79);
        step(1'b1, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        chk("rst_mid_xvalid", 32'(x_valid_m), 32'd0);
        chk("rst_mid_x",      32'(x_m),       32'd0);
        chk("rst_mid_busy",   32'(busy_m),    32'd0);
        repeat (10) step(1'b1, 1'b0, '0);
        chk("rst_mid_remnant", 32'(vcnt_m), 32'd3);

        // Randomized traffic with occasional resets
        pend = 1'b0;
        d    = '0;
        v    = 1'b0;
        for (int n = 0; n < 400; n++) begin
            r = ($urandom_range(0, 49) != 0);
            if (!pend) begin
                v = ($urandom_range(0, 3) != 0);
                d = W'($urandom);
            end
            step(r, v, d);
            pend = r && v && !xfer;
        end
        repeat (12) step(1'b1, 1'b0, '0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/piso_bit_serializer.md
Name: piso_bit_serializer

Overview:
Parallel-in, serial-out feeder for the bit-serial sequence detectors (single-bit input x). It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock on x. A one-word holding register allows back-to-back words to stream with no idle gap. When no word is in flight, x is driven to IDLE_BIT, so downstream detectors see a defined level.

Parameters:
WIDTH, 8, bits per word; must be >= 2.
MSB_FIRST, 1, 1 = din[WIDTH-1] is sent first; 0 = din[0] is sent first.
IDLE_BIT, 0, level driven on x when x_valid = 0.

Ports:
clk  input  1  rising-edge clock; the only clock.
rst  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
din  input  WIDTH  parallel word from the producer.
din_valid  input  1  producer has a word on din.
din_ready  output  1  block can accept a word this cycle.
x  output  WIDTH=1  serial bit to the downstream detector; registered.
x_valid  output  1  x carries a payload bit; registered.
last  output  1  x is the final bit of the current word; registered.
busy  output  1  shifter active or holding register full.

Behaviour:
- Reset (rst = 0 at a clock edge):
  - x = IDLE_BIT, x_valid = 0, last = 0.
  - Holding register cleared (empty); bit counter = 0; shifter set to IDLE.
  - din_ready is forced to 0 combinationally while rst = 0.
  - Words in flight are discarded. Reset mid-word truncates the output on the next edge.
- Handshake:
  - Transfer occurs on an edge where din_valid && din_ready.
  - din_ready = rst && !hold_full. It never depends on din_valid.
  - din must stay stable while din_valid = 1 and din_ready = 0.
- Shifter states:
  - IDLE: x_valid = 0, x = IDLE_BIT.
  - SHIFT: x_valid = 1, counter counts 0 .. WIDTH-1.
- Load rules, evaluated at each edge with rst = 1:
  - a) Shifter IDLE, or in SHIFT on its final bit (counter = WIDTH-1):
    - If hold_full: the hold word moves to the shifter and hold becomes empty.
    - Else, if a transfer occurs: din loads directly into the shifter (bypass).
    - Else: go to IDLE.
  - b) Shifter in SHIFT, not on its final bit: a transfer writes din into hold and sets hold_full.
  - c) A transfer can never occur while hold_full, because din_ready = 0.
- Latency: on a bypass load at edge N, the first bit appears on x from edge N until edge N+1.
- Each word occupies exactly WIDTH consecutive x_valid cycles.
- Back-to-back words: bit 0 of the next word follows the last bit of the previous word with no gap.
- last = 1 exactly when counter = WIDTH-1 and the state is SHIFT.
- busy = (state == SHIFT) || hold_full.
- Bit order:
  - MSB_FIRST = 1: bit k of the word is sent as din[WIDTH-1-k].
  - MSB_FIRST = 0: bit k is sent as din[k].
- Counter width is clog2(WIDTH). It wraps to 0 on every new load; no other wrap occurs.

Test Plan:
1. Reset then idle: rst = 0 for 2 cycles, then rst = 1 with no din_valid -> x = 0, x_valid = 0, last = 0, busy = 0, din_ready = 1 after release and 0 during reset.
2. Single word: WIDTH = 8, MSB_FIRST = 1, din = 8'hF9 accepted at edge N -> x = 1,1,1,1,1,0,0,1 on edges N..N+7, x_valid high for exactly 8 cycles, last high only in the 8th cycle, then x = 0 and x_valid = 0.
3. Streaming: hold din_valid = 1 with words 8'hF9, 8'h79, 8'hA5 -> 24 contiguous x_valid cycles with no gap. din_ready deasserts while hold is full and reasserts on the cycle after each hold-to-shifter move.
4. Backpressure: word 8'hF9 in SHIFT, 8'h79 in hold, present 8'h3C -> din_ready = 0 and 8'h3C is not accepted until 8'h79 moves to the shifter. Output order is F9, 79, 3C with no lost or duplicated bits.
5. LSB order: MSB_FIRST = 0, din = 8'h9F -> x = 1,1,1,1,1,0,0,1.
6. Reset mid-word: assert rst = 0 after 3 bits of 8'hF9 while hold is full -> on the next edge x_valid = 0, x = 0, busy = 0, and after release no remnant bits of either word appear.
